simon_round_ctrl: RTL
=====================

Name: simon_round_ctrl

Overview:
Sequences the Simon 128/256 round datapath for one block at a time, using round keys from the dual-port round-key memory.
- Accepts a start/ctrl request once the key schedule reports ready.
- Walks the key read address ascending (encrypt) or descending (decrypt), applying one round per cycle for 72 rounds.
- Presents the 128-bit result with a one-cycle done pulse.
- Sits between the top-level control FSM and the round-key memory / key-schedule pair.

Parameters:
ROUNDS, 72, number of Simon rounds (128/256 variant)
WORD, 64, Simon word width n
ADR_W, 7, round-key memory address width (must hold ROUNDS-1)

Ports:
clk  in  1  single clock, all state on rising edge
res_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only in IDLE
ctrl  in  1  0 = encrypt, 1 = decrypt; sampled with accepted start
key_ready  in  1  round-key memory fully written by key schedule
din  in  128  plaintext (enc) or ciphertext (dec); {x,y} = {din[127:64], din[63:0]}; sampled on accept
key_rd_adr  out  ADR_W  round-key memory read address (registered)
key_rd_data  in  WORD  round key; synchronous read, valid the cycle after key_rd_adr is sampled
busy  out  1  high from accept until the done cycle, inclusive
done  out  1  one-cycle pulse, dout valid
dout  out  128  result {x,y}; held until next accept

Behaviour:
- Reset (async, res_n low):
  - state = IDLE; key_rd_adr = 0, busy = 0, done = 0, dout = 0.
  - Reset mid-operation discards the block; no done is issued.
- States: IDLE, WAIT_KEY, LOAD, ROUND, FINISH (encodings in package).
- IDLE:
  - start & key_ready → LOAD.
  - start & !key_ready → WAIT_KEY.
  - In both cases latch din and ctrl, set busy, and set key_rd_adr = first index (0 for enc, ROUNDS-1 for dec).
- WAIT_KEY: hold; on key_ready → LOAD. start is ignored.
- LOAD (1 cycle):
  - Memory samples first address.
  - key_rd_adr steps to the next index (+1 enc, -1 dec).
  - Round counter = 0.
- ROUND (exactly ROUNDS cycles):
  - Each cycle: x' = y ^ f(x) ^ key_rd_data; y' = x, where f(x) = (rotl1(x) & rotl8(x)) ^ rotl2(x).
  - key_rd_adr steps each cycle, but never wraps outside 0..ROUNDS-1; it saturates on the final round.
  - After counter reaches ROUNDS-1 → FINISH.
- Decrypt handling:
  - Halves are swapped on load ({x,y} = {din[63:0], din[127:64]}) and swapped again on output.
  - Round keys are used in descending order, so the same round function inverts.
- FINISH:
  - done = 1 for one cycle; dout registered.
  - busy drops the following cycle → IDLE.
  - start is accepted again the cycle after FINISH.
- Latency: accept at cycle T → done at T+74 when key_ready is already high; WAIT_KEY cycles add directly.
- start while busy: ignored, with no queuing.
- Simultaneous start and key_ready rising in IDLE: key_ready is sampled that cycle, so the controller goes to WAIT_KEY if it was low at that edge.
- key_ready deasserting mid-operation: ignored; the key store owner guarantees stability.
- All arithmetic is modulo 2^WORD on rotations only; the address counter is ADR_W bits unsigned.

Decomposition:
- simon_pkg:
  - state encoding (one-hot, 5 bits)
  - ctrl encoding (CTRL_ENC = 0, CTRL_DEC = 1)
  - ROUNDS / WORD / ADR_W constants
  - f() function and rotate helpers
- Sub-module simon_round: combinational single round ({x,y}, k) → {x',y'}, shared with the future unrolled variant.

Test Plan:
- Encrypt known vector: key store preloaded with the schedule from key 1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100; din = 74206e69206d6f6f6d69732061207369, ctrl = 0 → done at T+74, dout = 8d2b5579afc8a3a03bf72a87efe7b868.
- Decrypt same vector: din = 8d2b5579afc8a3a03bf72a87efe7b868, ctrl = 1 → dout = 74206e69206d6f6f6d69732061207369; key_rd_adr sequence 71, 70, …, 0, never wraps to 127.
- key_ready low at start: accept, hold in WAIT_KEY for 10 cycles, then raise key_ready → done at T+84, correct ciphertext, busy high throughout.
- start pulsed during ROUND with different din/ctrl → ignored; result equals the first request; exactly one done pulse.
- res_n asserted at round 30 → outputs 0 immediately (async), no done; a following encrypt returns the correct ciphertext.
- Back-to-back: start held high continuously → new accept on the cycle after FINISH, done pulses 75 cycles apart; dout holds between pulses.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared Simon 128/256 constants, controller state encoding and round function helpers.
// Used by the round controller and the single-round datapath.
package simon_pkg;
  localparam int ROUNDS = 72;
  localparam int WORD   = 64;
  localparam int ADR_W  = 7;

  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(ROUNDS - 1);
  localparam logic [ADR_W-1:0] ADR_ONE  = ADR_W'(1);

  localparam logic CTRL_ENC = 1'b0;
  localparam logic CTRL_DEC = 1'b1;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_WAIT_KEY = 5'b00010,
    ST_LOAD     = 5'b00100,
    ST_ROUND    = 5'b01000,
    ST_FINISH   = 5'b10000
  } state_t;

  function automatic logic [WORD-1:0] rotl1(input logic [WORD-1:0] v);
    return {v[WORD-2:0], v[WORD-1]};
  endfunction

  function automatic logic [WORD-1:0] rotl2(input logic [WORD-1:0] v);
    return {v[WORD-3:0], v[WORD-1:WORD-2]};
  endfunction

  function automatic logic [WORD-1:0] rotl8(input logic [WORD-1:0] v);
    return {v[WORD-9:0], v[WORD-1:WORD-8]};
  endfunction

  function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] x);
    return (rotl1(x) & rotl8(x)) ^ rotl2(x);
  endfunction
endpackage

// File: rtl/simon_round.sv
// One combinational Simon round: {x,y},k -> {y ^ f(x) ^ k, x}; zero latency, no flow control.
// Kept standalone so an unrolled datapath can instantiate it directly.
module simon_round
  import simon_pkg::*;
(
  input  logic [2*WORD-1:0] i_xy,
  input  logic [WORD-1:0]   i_key,
  output logic [2*WORD-1:0] o_xy
);
  logic [WORD-1:0] w_x;
  logic [WORD-1:0] w_y;

  assign w_x  = i_xy[2*WORD-1:WORD];
  assign w_y  = i_xy[WORD-1:0];
  assign o_xy = {w_y ^ simon_f(w_x) ^ i_key, w_x};
endmodule

// File: rtl/simon_round_ctrl.sv
// Iterative Simon 128/256 block controller: accept -> done in 74 cycles plus any key wait.
// One block in flight; start is ignored while busy, no queuing.
module simon_round_ctrl
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic              ctrl,
  input  logic              key_ready,
  input  logic [2*WORD-1:0] din,
  output logic [ADR_W-1:0]  key_rd_adr,
  input  logic [WORD-1:0]   key_rd_data,
  output logic              busy,
  output logic              done,
  output logic [2*WORD-1:0] dout
);
  state_t              r_state;
  state_t              w_next;
  logic                r_dec;
  logic [2*WORD-1:0]   r_xy;
  logic [ADR_W-1:0]    r_cnt;
  logic [ADR_W-1:0]    r_adr;
  logic                r_busy;
  logic                r_done;
  logic [2*WORD-1:0]   r_dout;
  logic [2*WORD-1:0]   w_xy_nxt;
  logic [ADR_W-1:0]    w_adr_step;
  logic                w_last;

  simon_round u_round (
    .i_xy  (r_xy),
    .i_key (key_rd_data),
    .o_xy  (w_xy_nxt)
  );

  assign w_last = (r_cnt == ADR_LAST);

  // Address saturates at the end of its walk so it never wraps outside the key table.
  always_comb begin
    w_adr_step = r_adr;
    if (r_dec) begin
      if (r_adr != '0) w_adr_step = r_adr - ADR_ONE;
    end else begin
      if (r_adr != ADR_LAST) w_adr_step = r_adr + ADR_ONE;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = key_ready ? ST_LOAD : ST_WAIT_KEY;
      ST_WAIT_KEY: if (key_ready) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_ROUND;
      ST_ROUND:    if (w_last) w_next = ST_FINISH;
      ST_FINISH:   w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_dec  <= 1'b0;
      r_xy   <= '0;
      r_cnt  <= '0;
      r_adr  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dout <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // busy stays up through the done cycle and only drops here when no new start arrives
          r_busy <= start;
          if (start) begin
            r_dec <= (ctrl != CTRL_ENC);
            r_xy  <= (ctrl == CTRL_DEC) ? {din[WORD-1:0], din[2*WORD-1:WORD]} : din;
            r_adr <= (ctrl == CTRL_DEC) ? ADR_LAST : '0;
          end
        end
        ST_LOAD: begin
          r_adr <= w_adr_step;
          r_cnt <= '0;
        end
        ST_ROUND: begin
          r_xy  <= w_xy_nxt;
          r_adr <= w_adr_step;
          r_cnt <= r_cnt + ADR_ONE;
        end
        ST_FINISH: begin
          r_done <= 1'b1;
          r_dout <= r_dec ? {r_xy[WORD-1:0], r_xy[2*WORD-1:WORD]} : r_xy;
        end
        default: begin
          r_busy <= r_busy;
        end
      endcase
    end
  end

  assign key_rd_adr = r_adr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dout       = r_dout;
endmodule
